// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB2 transmit bit engine (SYNC, LSB-first shift, bit stuffing, NRZI, EOP).
// Define USB_TX_CRC16_EN to append CRC-16/USB over the bytes following the PID.
module usb_tx_serializer #(
    parameter int SYNC_BITS    = 8,
    parameter int EOP_SE0_BITS = 2,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dout,
    output logic       se0,
    output logic       oe,
    output logic       tx_underrun
);
    localparam int CMAX = SYNC_BITS > EOP_SE0_BITS ? (SYNC_BITS > 8 ? SYNC_BITS : 8)
                                                   : (EOP_SE0_BITS > 8 ? EOP_SE0_BITS : 8);
    localparam int CW = $clog2(CMAX) + 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [OW-1:0] ones, ones_n;
    logic [7:0]    sh, sh_n, hold, hold_n;
    logic          hold_full, hold_full_n, hold_last, hold_last_n;
    logic          cur_last, cur_last_n, last_acc, last_acc_n, pend, pend_n;
    logic          dout_n, se0_n, oe_n, und_n;
    logic          accept, emit, b, bnd;
`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc, crc_n;
    logic [1:0]    crc_ph, crc_ph_n;
    logic          is_pid, is_pid_n;
`endif

    assign tx_ready = !hold_full && !last_acc && (state == IDLE || state == SYNC || state == DATA);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ones_n      = ones;
        sh_n        = sh;
        hold_n      = hold;
        hold_full_n = hold_full;
        hold_last_n = hold_last;
        cur_last_n  = cur_last;
        last_acc_n  = last_acc;
        pend_n      = pend;
        dout_n      = dout;
        se0_n       = se0;
        oe_n        = oe;
        und_n       = 1'b0;
        emit        = 1'b0;
        b           = 1'b0;
        bnd         = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_n       = crc;
        crc_ph_n    = crc_ph;
        is_pid_n    = is_pid;
`endif
        if (accept) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
            hold_last_n = tx_last;
            last_acc_n  = last_acc | tx_last;
        end
        if (state == IDLE) begin
            cnt_n      = '0;
            ones_n     = '0;
            cur_last_n = 1'b0;
            pend_n     = 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_n      = 16'hFFFF;
            crc_ph_n   = 2'd0;
`endif
            if (accept)
                state_n = SYNC;
        end else if (bit_en) begin
            case (state)
                SYNC: begin
                    b      = cnt == CW'(SYNC_BITS - 1);
                    emit   = 1'b1;
                    ones_n = OW'(b);
                    cnt_n  = cnt + 1'b1;
                    bnd    = b;
                end
                DATA: begin
                    b      = sh[0];
                    emit   = 1'b1;
                    sh_n   = {1'b0, sh[7:1]};
                    cnt_n  = cnt + 1'b1;
                    ones_n = b ? ones + 1'b1 : '0;
                    pend_n = cnt == CW'(7);
`ifdef USB_TX_CRC16_EN
                    if (crc_ph == 2'd0 && !is_pid)
                        crc_n = {1'b0, crc[15:1]} ^ ((crc[0] ^ b) ? 16'hA001 : 16'h0000);
`endif
                    // a stuff bit owed at a byte end is sent before the boundary is taken
                    if (ones_n == OW'(STUFF_LIMIT))
                        state_n = STUFF;
                    else
                        bnd = pend_n;
                end
                STUFF: begin
                    emit   = 1'b1;
                    ones_n = '0;
                    if (pend)
                        bnd = 1'b1;
                    else
                        state_n = DATA;
                end
                EOP_SE0: begin
                    se0_n = 1'b1;
                    oe_n  = 1'b1;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(EOP_SE0_BITS - 1)) begin
                        state_n = EOP_J;
                        cnt_n   = '0;
                    end
                end
                EOP_J: begin
                    dout_n = 1'b1;
                    se0_n  = 1'b0;
                    oe_n   = cnt == '0;
                    cnt_n  = CW'(1);
                    if (cnt != '0) begin
                        state_n    = IDLE;
                        last_acc_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (emit) begin
                dout_n = b ? dout : ~dout;
                se0_n  = 1'b0;
                oe_n   = 1'b1;
            end
            if (bnd) begin
                cnt_n   = '0;
                state_n = DATA;
`ifdef USB_TX_CRC16_EN
                if (crc_ph == 2'd1) begin
                    sh_n     = ~crc_n[15:8];
                    crc_ph_n = 2'd2;
                end else if (crc_ph == 2'd2)
                    state_n = EOP_SE0;
                else if (cur_last && !is_pid) begin
                    sh_n     = ~crc_n[7:0];
                    crc_ph_n = 2'd1;
                end else
`endif
                if (cur_last)
                    state_n = EOP_SE0;
                else if (hold_full) begin
                    sh_n        = hold;
                    hold_full_n = 1'b0;
                    cur_last_n  = hold_last;
`ifdef USB_TX_CRC16_EN
                    is_pid_n    = state == SYNC;
`endif
                end else begin
                    und_n   = 1'b1;
                    state_n = EOP_SE0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ones        <= '0;
            sh          <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            hold_last   <= 1'b0;
            cur_last    <= 1'b0;
            last_acc    <= 1'b0;
            pend        <= 1'b0;
            dout        <= 1'b1;
            se0         <= 1'b0;
            oe          <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc         <= 16'hFFFF;
            crc_ph      <= 2'd0;
            is_pid      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ones        <= ones_n;
            sh          <= sh_n;
            hold        <= hold_n;
            hold_full   <= hold_full_n;
            hold_last   <= hold_last_n;
            cur_last    <= cur_last_n;
            last_acc    <= last_acc_n;
            pend        <= pend_n;
            dout        <= dout_n;
            se0         <= se0_n;
            oe          <= oe_n;
            tx_underrun <= und_n;
`ifdef USB_TX_CRC16_EN
            crc         <= crc_n;
            crc_ph      <= crc_ph_n;
            is_pid      <= is_pid_n;
`endif
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: line-symbol model (sync + raw bits -> stuffing -> NRZI -> EOP) checked
// against the serializer on every bit time, plus freeze, handshake, underrun and reset checks.
module tb_usb_tx_serializer;
    localparam int SYNC_BITS = 8, EOP_SE0_BITS = 2, STUFF_LIMIT = 6;

    logic       clock = 1'b0, reset = 1'b1, bit_en = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, dout, se0, oe, tx_underrun;

    int         checks = 0, failures = 0, en_div = 1, und_cnt = 0;
    logic       active = 1'b0, m_en, m_rs;
    logic [2:0] prev = 3'b001, cur, e;
    logic [15:0] v;
    logic [7:0] pkt[$];
    logic [2:0] mdl[$], exp_q[$];

    usb_tx_serializer #(.SYNC_BITS(SYNC_BITS), .EOP_SE0_BITS(EOP_SE0_BITS), .STUFF_LIMIT(STUFF_LIMIT)) dut (
        .clock(clock), .reset(reset), .bit_en(bit_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .dout(dout), .se0(se0), .oe(oe), .tx_underrun(tx_underrun)
    );

    always #5 clock = ~clock;

    initial begin : en_gen
        int d = 0;
        forever begin
            @(negedge clock);
            bit_en = (d == 0);
            d = (d + 1 >= en_div) ? 0 : d + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // symbols are {oe, se0, dout}; dout is ignored while se0 is expected
    always @(posedge clock) begin
        m_en = bit_en;
        m_rs = reset;
        #1;
        cur = {oe, se0, dout};
        if (!m_rs) begin
            if (tx_underrun) und_cnt++;
            if (!m_en) begin
                checks++;
                if (cur !== prev) begin
                    failures++;
                    $display("FAIL freeze got=%b want=%b", cur, prev);
                end
            end else if (oe || active) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL line_symbol got=%b want=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e[1] ? (cur[2:1] !== e[2:1]) : (cur !== e)) begin
                        failures++;
                        $display("FAIL line_symbol got=%b want=%b", cur, e);
                    end
                end
            end
            if (m_en) active = oe;
        end
        prev = cur;
    end

    function automatic logic [15:0] crc16(input int first);
        logic [15:0] c = 16'hFFFF;
        for (int i = first; i < pkt.size(); i++) begin
            c ^= {8'h00, pkt[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input bit complete);
        logic raw[$];
        logic lvl = 1'b1;
        int   run = 0;
        mdl.delete();
        for (int i = 0; i < SYNC_BITS; i++) raw.push_back(i == SYNC_BITS - 1);
        foreach (pkt[i]) for (int j = 0; j < 8; j++) raw.push_back(pkt[i][j]);
        if (complete && pkt.size() > 1) begin
`ifdef USB_TX_CRC16_EN
            logic [15:0] c;
            c = crc16(1);
            for (int j = 0; j < 16; j++) raw.push_back(c[j]);
`endif
        end
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            mdl.push_back({2'b10, lvl});
            run = raw[i] ? run + 1 : 0;
            if (run == STUFF_LIMIT) begin
                lvl = ~lvl;
                mdl.push_back({2'b10, lvl});
                run = 0;
            end
        end
        repeat (EOP_SE0_BITS) mdl.push_back(3'b110);
        mdl.push_back(3'b101);
        mdl.push_back(3'b001);
    endtask

    task automatic send(input bit complete);
        build(complete);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        und_cnt = 0;
        foreach (pkt[i]) begin
            int t = 0;
            @(negedge clock);
            tx_valid = 1'b1;
            tx_data  = pkt[i];
            tx_last  = complete && (i == pkt.size() - 1);
            while (!tx_ready && t < 2000) begin
                @(negedge clock);
                t++;
            end
            chk("byte_accepted", t < 2000, 1);
            @(posedge clock);
        end
        @(negedge clock);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic finish_pkt(input int want_und, input bit want_ready_low);
        int t = 0, bad = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            @(negedge clock);
            t++;
            if (want_ready_low && exp_q.size() > 0 && tx_ready) bad++;
        end
        chk("packet_done", exp_q.size(), 0);
        chk("underrun_pulses", und_cnt, want_und);
        if (want_ready_low) chk("ready_low_until_idle", bad, 0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_dout", dout, 1);
        chk("reset_se0", se0, 0);
        chk("reset_oe", oe, 0);
        chk("reset_underrun", tx_underrun, 0);
        chk("reset_ready", tx_ready, 1);
        reset = 1'b0;
        pkt = '{8'h00};
        build(1);
        for (int i = 0; i < 16; i++) v[i] = mdl[i][0];
        chk("model_00_dout", v, 16'h552A);
        chk("model_00_len", mdl.size(), 20);
        pkt = '{8'hFF};
        build(1);
        v = '0;
        for (int i = 0; i < 9; i++) v[i] = mdl[8 + i][0];
        chk("model_ff_dout", v, 16'h01E0);
        chk("model_ff_len", mdl.size(), 21);
        pkt = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc", crc16(1), 16'hB4C8);
        repeat (2) @(negedge clock);
        pkt = '{8'h00};
        send(1);
        finish_pkt(0, 1);
        pkt = '{8'hFF};
        send(1);
        finish_pkt(0, 1);
        pkt = '{8'hA5, 8'h3C, 8'h0F};
        send(1);
        finish_pkt(0, 1);
        pkt = '{8'h11};
        send(0);
        finish_pkt(1, 0);
        pkt = '{8'h55};
        send(1);
        repeat (12) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        active = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset_oe", oe, 0);
        chk("midreset_dout", dout, 1);
        chk("midreset_se0", se0, 0);
        chk("midreset_ready", tx_ready, 1);
        chk("midreset_underrun", tx_underrun, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        pkt = '{8'h3C};
        send(1);
        finish_pkt(0, 1);
        en_div = 3;
        pkt = '{8'h7E, 8'hFC};
        send(1);
        finish_pkt(0, 1);
        en_div = 1;
`ifdef USB_TX_CRC16_EN
        pkt = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(1);
        finish_pkt(0, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
